// File: rtl/id_inst_queue_if.sv
// id_inst_queue_if
//  Bundles the Icache response, the ID control inputs and the queue head/status
//  outputs that connect the instruction queue to fetch, flow control and decode.
//  master : fetch / flow-control / decode side. It drives the Icache and
//           control signals and reads the head and status.
//  slave  : the instruction queue itself.
//  Ports carried:
//   Icache_ready_i/Icache_inst_i/Icache_pc_i   fetched {pc,inst}, valid when ready
//   fc_flush_id_i, fc_stall_id_i, id_load_use_flag_i   ID control
//   iq_inst_o/iq_pc_o/iq_valid_o                        head presented to decode
//   iq_full_o/iq_empty_o/iq_count_o/iq_overflow_o       occupancy and status
interface id_inst_queue_if #(
   parameter int XLEN  = 32,
   parameter int DEPTH = 4
);
   localparam int CNT_W = $clog2(DEPTH) + 1;

   logic             Icache_ready_i;
   logic [XLEN-1:0]  Icache_inst_i;
   logic [XLEN-1:0]  Icache_pc_i;
   logic             fc_flush_id_i;
   logic             fc_stall_id_i;
   logic             id_load_use_flag_i;
   logic [XLEN-1:0]  iq_inst_o;
   logic [XLEN-1:0]  iq_pc_o;
   logic             iq_valid_o;
   logic             iq_full_o;
   logic             iq_empty_o;
   logic [CNT_W-1:0] iq_count_o;
   logic             iq_overflow_o;

   modport master (
      output Icache_ready_i, Icache_inst_i, Icache_pc_i,
             fc_flush_id_i, fc_stall_id_i, id_load_use_flag_i,
      input  iq_inst_o, iq_pc_o, iq_valid_o,
             iq_full_o, iq_empty_o, iq_count_o, iq_overflow_o
   );

   modport slave (
      input  Icache_ready_i, Icache_inst_i, Icache_pc_i,
             fc_flush_id_i, fc_stall_id_i, id_load_use_flag_i,
      output iq_inst_o, iq_pc_o, iq_valid_o,
             iq_full_o, iq_empty_o, iq_count_o, iq_overflow_o
   );
endinterface

// File: rtl/id_inst_queue.sv
// id_inst_queue
//  Instruction queue between the Icache and the ID decoder. It holds up to DEPTH
//  {pc,inst} pairs while ID is stalled or held for load-use, so fetch can run
//  ahead. When the queue is empty, Icache data is bypassed to ID with zero
//  latency. A flush empties the queue and discards Icache responses for
//  FLUSH_DROP cycles after the flush cycle.
//  Ports:
//   clk, rst_n : core clock, asynchronous active-low reset
//   iq         : id_inst_queue_if.slave (Icache in, ID control in, head/status out)
module id_inst_queue #(
   parameter int              DEPTH      = 4,
   parameter int              XLEN       = 32,
   parameter logic [XLEN-1:0] NOP_INST   = 32'h00000013,
   parameter int              FLUSH_DROP = 1
) (
   input logic            clk,
   input logic            rst_n,
   id_inst_queue_if.slave iq
);
   localparam int               PTR_W     = $clog2(DEPTH);
   localparam int               CNT_W     = PTR_W + 1;
   localparam logic [CNT_W-1:0] FULL_CNT  = CNT_W'(DEPTH);
   localparam logic [1:0]       DROP_INIT = 2'(FLUSH_DROP);

   logic [XLEN-1:0]  inst_mem_q [DEPTH];
   logic [XLEN-1:0]  inst_mem_d [DEPTH];
   logic [XLEN-1:0]  pc_mem_q   [DEPTH];
   logic [XLEN-1:0]  pc_mem_d   [DEPTH];
   logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
   logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
   logic [CNT_W-1:0] count_q, count_d;
   logic [1:0]       drop_cnt_q, drop_cnt_d;
   logic             overflow_q, overflow_d;

   logic             in_ok, empty, full, deq, pop, enq;
   logic             head_valid;
   logic [XLEN-1:0]  head_inst, head_pc;

   always_comb begin
      empty = (count_q == '0);
      full  = (count_q == FULL_CNT);
      // Responses are ignored in the flush cycle and while the drop window runs.
      in_ok = iq.Icache_ready_i & ~iq.fc_flush_id_i & (drop_cnt_q == 2'd0);

      head_valid = 1'b0;
      head_inst  = NOP_INST;
      head_pc    = '0;
      if (!iq.fc_flush_id_i) begin
         if (!empty) begin
            head_valid = 1'b1;
            head_inst  = inst_mem_q[rd_ptr_q];
            head_pc    = pc_mem_q[rd_ptr_q];
         end else if (in_ok) begin
            head_valid = 1'b1;
            head_inst  = iq.Icache_inst_i;
            head_pc    = iq.Icache_pc_i;
         end
      end

      // head_valid is already 0 during a flush, so deq never fires then.
      deq = head_valid & ~iq.fc_stall_id_i & ~iq.id_load_use_flag_i;
      pop = deq & ~empty;
      // A bypassed instruction consumed this cycle is never stored; when full,
      // a simultaneous pop frees the slot being written.
      enq = in_ok & ~(empty & deq) & (~full | deq);

      inst_mem_d = inst_mem_q;
      pc_mem_d   = pc_mem_q;
      if (enq) begin
         inst_mem_d[wr_ptr_q] = iq.Icache_inst_i;
         pc_mem_d[wr_ptr_q]   = iq.Icache_pc_i;
      end

      rd_ptr_d   = rd_ptr_q + PTR_W'(pop);
      wr_ptr_d   = wr_ptr_q + PTR_W'(enq);
      count_d    = count_q + CNT_W'(enq) - CNT_W'(pop);
      overflow_d = overflow_q | (in_ok & full & ~deq);
      drop_cnt_d = (drop_cnt_q != 2'd0) ? drop_cnt_q - 2'd1 : 2'd0;

      if (iq.fc_flush_id_i) begin
         rd_ptr_d   = '0;
         wr_ptr_d   = '0;
         count_d    = '0;
         overflow_d = 1'b0;
         drop_cnt_d = DROP_INIT;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < DEPTH; i++) begin
            inst_mem_q[i] <= NOP_INST;
            pc_mem_q[i]   <= '0;
         end
         rd_ptr_q   <= '0;
         wr_ptr_q   <= '0;
         count_q    <= '0;
         drop_cnt_q <= 2'd0;
         overflow_q <= 1'b0;
      end else begin
         inst_mem_q <= inst_mem_d;
         pc_mem_q   <= pc_mem_d;
         rd_ptr_q   <= rd_ptr_d;
         wr_ptr_q   <= wr_ptr_d;
         count_q    <= count_d;
         drop_cnt_q <= drop_cnt_d;
         overflow_q <= overflow_d;
      end
   end

   assign iq.iq_inst_o     = head_inst;
   assign iq.iq_pc_o       = head_pc;
   assign iq.iq_valid_o    = head_valid;
   assign iq.iq_full_o     = full;
   assign iq.iq_empty_o    = empty;
   assign iq.iq_count_o    = count_q;
   assign iq.iq_overflow_o = overflow_q;
endmodule

// File: tb/tb_id_inst_queue.sv
// tb_id_inst_queue
//  Table of per-cycle vectors covering bypass, full/overflow, load-use hold,
//  flush with a drop window and full-queue streaming, followed by a mid-stream
//  reset sequence and a random streaming phase checked against a queue.
module tb_id_inst_queue;
   localparam int XLEN  = 32;
   localparam int DEPTH = 4;
   localparam logic [31:0] NOP = 32'h00000013;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   id_inst_queue_if #(.XLEN(XLEN), .DEPTH(DEPTH)) bus ();

   id_inst_queue #(.DEPTH(DEPTH), .XLEN(XLEN), .NOP_INST(NOP), .FLUSH_DROP(1)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .iq    (bus)
   );

   typedef struct {
      logic        rdy;
      logic [31:0] pc;
      logic        stall;
      logic        lu;
      logic        flush;
      logic        ev;
      logic [31:0] epc;
      int          ecnt;
      logic        eovf;
   } vec_t;

   vec_t        vecs[$];
   logic [31:0] sb[$];
   int          n_cmp = 0;
   int          n_err = 0;

   function automatic logic [31:0] inst_of(input logic [31:0] pc);
      return pc ^ 32'h0050_0193;   // pc 0x100 -> 0x00500093
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic add(input logic rdy, input logic [31:0] pc, input logic stall,
                      input logic lu, input logic flush, input logic ev,
                      input logic [31:0] epc, input int ecnt, input logic eovf);
      vec_t v;
      v.rdy = rdy; v.pc = pc; v.stall = stall; v.lu = lu; v.flush = flush;
      v.ev = ev; v.epc = epc; v.ecnt = ecnt; v.eovf = eovf;
      vecs.push_back(v);
   endtask

   task automatic drive(input logic rdy, input logic [31:0] pc, input logic stall,
                        input logic lu, input logic flush);
      bus.Icache_ready_i     = rdy;
      bus.Icache_pc_i        = pc;
      bus.Icache_inst_i      = inst_of(pc);
      bus.fc_stall_id_i      = stall;
      bus.id_load_use_flag_i = lu;
      bus.fc_flush_id_i      = flush;
   endtask

   task automatic chk_reset_vals(input string tag);
      chk({tag, "_valid"}, 32'(bus.iq_valid_o), 32'd0);
      chk({tag, "_inst"}, bus.iq_inst_o, NOP);
      chk({tag, "_pc"}, bus.iq_pc_o, 32'd0);
      chk({tag, "_empty"}, 32'(bus.iq_empty_o), 32'd1);
      chk({tag, "_full"}, 32'(bus.iq_full_o), 32'd0);
      chk({tag, "_count"}, 32'(bus.iq_count_o), 32'd0);
      chk({tag, "_ovf"}, 32'(bus.iq_overflow_o), 32'd0);
   endtask

   initial begin
      drive(1'b0, 32'h0, 1'b0, 1'b0, 1'b0);

      // 1: bypass on an empty queue
      add(1, 32'h100, 0, 0, 0, 1, 32'h100, 0, 0);
      add(0, 32'h0,   0, 0, 0, 0, 32'h0,   0, 0);
      // 2: stall while five responses arrive; fifth is dropped
      for (int k = 0; k < 5; k++)
         add(1, 32'h100 + 32'(4*k), 1, 0, 0, 1, 32'h100, (k < 4) ? k : 4, 0);
      add(0, 32'h0, 1, 0, 0, 1, 32'h100, 4, 1);
      for (int k = 0; k < 4; k++)
         add(0, 32'h0, 0, 0, 0, 1, 32'h100 + 32'(4*k), 4 - k, 1);
      add(0, 32'h0, 0, 0, 0, 0, 32'h0, 0, 1);
      // 3: load-use hold on head 0x200
      add(1, 32'h200, 1, 0, 0, 1, 32'h200, 0, 1);
      add(1, 32'h204, 1, 0, 0, 1, 32'h200, 1, 1);
      add(0, 32'h0,   0, 1, 0, 1, 32'h200, 2, 1);
      add(0, 32'h0,   0, 0, 0, 1, 32'h200, 2, 1);
      add(0, 32'h0,   0, 0, 0, 1, 32'h204, 1, 1);
      add(0, 32'h0,   0, 0, 0, 0, 32'h0,   0, 1);
      // 4: flush with three entries and a response present, then drop window
      for (int k = 0; k < 3; k++)
         add(1, 32'h300 + 32'(4*k), 1, 0, 0, 1, 32'h300, k, 1);
      add(1, 32'h30C, 0, 0, 1, 0, 32'h0,   3, 1);
      add(1, 32'h380, 0, 0, 0, 0, 32'h0,   0, 0);
      add(1, 32'h400, 0, 0, 0, 1, 32'h400, 0, 0);
      add(0, 32'h0,   0, 0, 0, 0, 32'h0,   0, 0);
      // 5: full queue with enq+deq every cycle for 8 cycles, then drain
      for (int k = 0; k < 4; k++)
         add(1, 32'h500 + 32'(4*k), 1, 0, 0, 1, 32'h500, k, 0);
      for (int k = 0; k < 8; k++)
         add(1, 32'h510 + 32'(4*k), 0, 0, 0, 1, 32'h500 + 32'(4*k), 4, 0);
      for (int k = 0; k < 4; k++)
         add(0, 32'h0, 0, 0, 0, 1, 32'h520 + 32'(4*k), 4 - k, 0);
      add(0, 32'h0, 0, 0, 0, 0, 32'h0, 0, 0);

      #1 chk_reset_vals("por");
      #11 rst_n = 1'b1;
      @(posedge clk); #1;

      foreach (vecs[i]) begin
         vec_t v;
         v = vecs[i];
         drive(v.rdy, v.pc, v.stall, v.lu, v.flush);
         #2;
         chk($sformatf("v%0d_valid", i), 32'(bus.iq_valid_o), 32'(v.ev));
         chk($sformatf("v%0d_pc", i), bus.iq_pc_o, v.epc);
         chk($sformatf("v%0d_inst", i), bus.iq_inst_o, v.ev ? inst_of(v.epc) : NOP);
         chk($sformatf("v%0d_count", i), 32'(bus.iq_count_o), 32'(v.ecnt));
         chk($sformatf("v%0d_full", i), 32'(bus.iq_full_o), 32'(v.ecnt == DEPTH));
         chk($sformatf("v%0d_empty", i), 32'(bus.iq_empty_o), 32'(v.ecnt == 0));
         chk($sformatf("v%0d_ovf", i), 32'(bus.iq_overflow_o), 32'(v.eovf));
         @(posedge clk); #1;
      end

      // 6: asynchronous reset mid-stream with two entries queued
      drive(1, 32'h700, 1, 0, 0); @(posedge clk); #1;
      drive(1, 32'h704, 1, 0, 0); @(posedge clk); #1;
      chk("pre_rst_count", 32'(bus.iq_count_o), 32'd2);
      drive(0, 32'h0, 0, 0, 0);
      rst_n = 1'b0;
      #1 chk_reset_vals("mid_rst");
      @(posedge clk); #1;
      rst_n = 1'b1;
      drive(1, 32'h600, 0, 0, 0);
      #2;
      chk("post_rst_valid", 32'(bus.iq_valid_o), 32'd1);
      chk("post_rst_pc", bus.iq_pc_o, 32'h600);
      chk("post_rst_inst", bus.iq_inst_o, inst_of(32'h600));
      @(posedge clk); #1;
      drive(0, 32'h0, 0, 0, 0);
      #2 chk("post_rst_count", 32'(bus.iq_count_o), 32'd0);
      @(posedge clk); #1;

      // Random streaming: fetch only issues when the bench's own occupancy
      // leaves room, so every response is expected to come out in order.
      for (int k = 0; k < 300; k++) begin
         logic rdy, stall, lu;
         logic [31:0] pc;
         pc    = 32'h1000 + 32'(4*k);
         rdy   = (sb.size() < DEPTH) && ($urandom_range(3) != 0);
         stall = ($urandom_range(2) == 0);
         lu    = ($urandom_range(4) == 0);
         if (k >= 280) rdy = 1'b0;
         chk("rnd_count", 32'(bus.iq_count_o), 32'(sb.size()));
         if (rdy) sb.push_back(pc);
         drive(rdy, pc, stall, lu, 1'b0);
         #2;
         chk("rnd_valid", 32'(bus.iq_valid_o), 32'(sb.size() != 0));
         if (sb.size() != 0) begin
            chk("rnd_pc", bus.iq_pc_o, sb[0]);
            chk("rnd_inst", bus.iq_inst_o, inst_of(sb[0]));
            if (!stall && !lu) void'(sb.pop_front());
         end
         chk("rnd_ovf", 32'(bus.iq_overflow_o), 32'd0);
         @(posedge clk); #1;
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule
